// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the single-issue RV32 core.
//
// Generates the PC and issues word requests to instruction memory. In-order
// responses are buffered in a small FIFO, and one instruction plus its PC is
// handed to the decoder per cycle over a valid/ready handshake. A redirect
// flushes buffered and in-flight fetches and restarts at the new PC.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  buffer entries and outstanding-request cap (power of two, >= 2)
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   imem_req/addr/gnt               request channel to instruction memory
//   imem_rvalid/rdata               in-order response channel
//   inst_valid/ready/instruction/inst_pc   decoder handshake (zeros when idle)
//   redirect_valid/pc               flush and restart from execute
//   fetch_fault                     sticky misaligned-redirect flag
//
// Optional feature: define FETCH_MISALIGN_EN to trap misaligned redirects
// (fetch_fault set, fetch halted). Without it, redirect_pc[1:0] is ignored.

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      buf_pc   [FIFO_DEPTH];
    logic [31:0]      buf_data [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill_ptr;
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] filled_cnt;
    logic [CNT_W-1:0] kill_cnt;
    logic             fault;

    logic             pop;
    logic             grant;
    logic             rsp_kill;
    logic             rsp_keep;
    logic [CNT_W-1:0] unfilled;
    logic [CNT_W-1:0] redirect_kill;
    logic [SUM_W-1:0] credit_used;
    logic [31:0]      redirect_pc_aligned;

    // Responses fill in order, so filled entries always form a prefix from head.
    assign inst_valid  = (filled_cnt != '0);
    assign pop         = inst_valid & inst_ready;
    assign unfilled    = alloc_cnt - filled_cnt;

    // Pop returns its credit in the same cycle to sustain one fetch per cycle.
    assign credit_used = SUM_W'(alloc_cnt) + SUM_W'(kill_cnt) - SUM_W'(pop);
    assign imem_req    = rst_n & ~redirect_valid & ~fault
                       & (credit_used < SUM_W'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req & imem_gnt;

    // Responses for flushed requests are swallowed before any are written.
    assign rsp_kill    = imem_rvalid & (kill_cnt != '0);
    assign rsp_keep    = imem_rvalid & (kill_cnt == '0) & (unfilled != '0);

    // A response landing on the redirect cycle is retired as a kill.
    assign redirect_kill = kill_cnt + unfilled - CNT_W'(rsp_kill | rsp_keep);
    assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

    assign instruction = inst_valid ? buf_data[head] : 32'd0;
    assign inst_pc     = inst_valid ? buf_pc[head]   : 32'd0;
    assign fetch_fault = fault;

    // PC, pointers and occupancy counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= {RESET_PC[31:2], 2'b00};
            head       <= '0;
            tail       <= '0;
            fill_ptr   <= '0;
            alloc_cnt  <= '0;
            filled_cnt <= '0;
            kill_cnt   <= '0;
        end else if (redirect_valid) begin
            fetch_pc   <= redirect_pc_aligned;
            head       <= '0;
            tail       <= '0;
            fill_ptr   <= '0;
            alloc_cnt  <= '0;
            filled_cnt <= '0;
            kill_cnt   <= redirect_kill;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
                tail     <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (rsp_keep) begin
                fill_ptr <= fill_ptr + PTR_W'(1);
            end
            alloc_cnt  <= alloc_cnt + CNT_W'(grant) - CNT_W'(pop);
            filled_cnt <= filled_cnt + CNT_W'(rsp_keep) - CNT_W'(pop);
            kill_cnt   <= kill_cnt - CNT_W'(rsp_kill);
        end
    end

    // Buffer storage; validity is tracked by the counters, so no reset needed.
    always_ff @(posedge clk) begin
        if (grant) begin
            buf_pc[tail] <= fetch_pc;
        end
        if (rsp_keep && !redirect_valid) begin
            buf_data[fill_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_MISALIGN_EN
    // Sticky trap on a misaligned redirect target; halts all further fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fault <= 1'b1;
        end
    end
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with configurable grant
// rate and response latency, a scoreboard of expected PCs pushed at grant time,
// and an independent monitor that pops and compares on every decoder accept.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .instruction   (instruction),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          cyc       = 0;
    bit          in_reset  = 1'b1;
    int unsigned gnt_pct   = 100;
    int unsigned lat_min   = 1;
    int unsigned lat_max   = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] sb_pc[$];
    logic [31:0] model_pc  = RESET_PC;
    bit          faulted   = 1'b0;
    int          pop_cnt   = 0;
    int          grant_cnt = 0;
    logic [31:0] mon_exp;
    bit          hold_q    = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_ins;
    int          p0;
    int          g0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Memory: grant drawn per cycle, responses in order once their due cycle arrives.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            imem_gnt = ($urandom_range(100, 1) <= gnt_pct);
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mq_addr[0]);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Bus observer: tracks grants, responses and redirects; pushes expectations.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!in_reset) begin
                if (faulted) check("req_after_fault", 32'(imem_req), 32'd0);
                if (imem_rvalid && mq_addr.size() > 0) begin
                    void'(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
                if (redirect_valid) begin
                    check("req_in_redirect", 32'(imem_req), 32'd0);
                    sb_pc.delete();
`ifdef FETCH_MISALIGN_EN
                    if (redirect_pc[1:0] != 2'b00) faulted = 1'b1;
`endif
                    model_pc = {redirect_pc[31:2], 2'b00};
                end else if (imem_req && imem_gnt) begin
                    check("imem_addr", imem_addr, model_pc);
                    mq_addr.push_back(imem_addr);
                    mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                    sb_pc.push_back(model_pc);
                    model_pc  = model_pc + 32'd4;
                    grant_cnt = grant_cnt + 1;
                end
            end
        end
    end

    // Monitor: compares every accepted instruction against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (in_reset) begin
                hold_q = 1'b0;
            end else begin
                if (hold_q) begin
                    check("hold_valid", 32'(inst_valid), 32'd1);
                    check("hold_pc", inst_pc, hold_pc);
                    check("hold_instr", instruction, hold_ins);
                end
                if (inst_valid && inst_ready) begin
                    if (sb_pc.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
                    end else begin
                        mon_exp = sb_pc.pop_front();
                        check("inst_pc", inst_pc, mon_exp);
                        check("instruction", instruction, mem_word(mon_exp));
                        pop_cnt = pop_cnt + 1;
                    end
                end
                if (!inst_valid) begin
                    check("idle_instruction", instruction, 32'd0);
                    check("idle_pc", inst_pc, 32'd0);
                end
                hold_q   = inst_valid && !inst_ready && !redirect_valid;
                hold_pc  = inst_pc;
                hold_ins = instruction;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);

        // Release and first request.
        @(negedge clk);
        #1;
        rst_n      = 1'b1;
        in_reset   = 1'b0;
        inst_ready = 1'b1;
        #2;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        @(posedge clk);
        #2;
        check("first_valid_early", 32'(inst_valid), 32'd0);
        @(posedge clk);
        #2;
        check("first_valid", 32'(inst_valid), 32'd1);
        check("first_pc", inst_pc, RESET_PC);

        // Sustained throughput with 1-cycle memory.
        p0 = pop_cnt;
        repeat (20) @(posedge clk);
        #2;
        check("throughput", 32'(pop_cnt - p0), 32'd20);

        // Decoder stall: buffer fills, requests stop, head held.
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        g0 = grant_cnt;
        repeat (10) @(posedge clk);
        #2;
        check("req_when_full", 32'(imem_req), 32'd0);
        check("valid_when_full", 32'(inst_valid), 32'd1);
        check("stall_grants_le_depth", 32'(grant_cnt - g0 <= int'(DEPTH)), 32'd1);
        inst_ready = 1'b1;
        p0 = pop_cnt;
        repeat (4) @(posedge clk);
        #2;
        check("release_pops", 32'(pop_cnt - p0), 32'd4);

        // Redirect with requests in flight on a 3-cycle memory.
        lat_min = 3;
        lat_max = 3;
        repeat (12) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        #1;
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        repeat (20) @(posedge clk);

        // Redirect coinciding with a pop and a response.
        lat_min = 1;
        lat_max = 1;
        repeat (10) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check("coincide_setup", 32'(inst_valid & inst_ready & imem_rvalid), 32'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        #1;
        check("coincide_addr", imem_addr, 32'h0000_0200);
        repeat (12) @(posedge clk);

        // PC wrap across 2^32.
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Random grant, latency, ready and redirects.
        gnt_pct = 70;
        lat_min = 1;
        lat_max = 5;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            inst_ready = ($urandom_range(99, 0) < 70);
            if ($urandom_range(99, 0) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_1000 + (32'($urandom_range(1023, 0)) << 2);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        gnt_pct        = 100;
        lat_min        = 1;
        lat_max        = 1;
        repeat (10) @(posedge clk);

        // Misaligned redirect target.
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_EN
        check("misalign_fault", 32'(fetch_fault), 32'd1);
        check("misalign_req", 32'(imem_req), 32'd0);
        repeat (10) @(posedge clk);
        #2;
        check("misalign_valid", 32'(inst_valid), 32'd0);
        check("misalign_sticky", 32'(fetch_fault), 32'd1);
`else
        check("misalign_fault", 32'(fetch_fault), 32'd0);
        check("misalign_req", 32'(imem_req), 32'd1);
        check("misalign_addr", imem_addr, 32'h0000_0100);
        repeat (10) @(posedge clk);
`endif

        // Drain: stop granting and let every outstanding fetch be delivered.
        gnt_pct = 0;
        for (int i = 0; i < 200; i++) begin
            if (sb_pc.size() == 0 && mq_addr.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_scoreboard", 32'(sb_pc.size()), 32'd0);
        check("drain_memory", 32'(mq_addr.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-issue RV32 core. Generates the program counter, issues word requests to the instruction memory, buffers in-order responses in a small FIFO, and presents one 32-bit instruction plus its PC per cycle to the decoder over a valid/ready handshake. Redirects from execute (branch/jump) flush all buffered and in-flight fetches and restart at the new PC.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: instruction buffer entries. Must be a power of two, ≥2. Also the cap on outstanding memory requests.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address of the request (bits [1:0] always 00).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- inst_valid  out  1  buffer head holds a returned instruction.
- inst_ready  in  1  decoder accepts the head this cycle.
- instruction  out  32  head instruction; 0 when inst_valid=0.
- inst_pc  out  32  PC of the head instruction; 0 when inst_valid=0.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address.
- fetch_fault  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers: fetch_pc, FIFO (per entry: pc, data, filled), alloc_cnt (entries allocated), kill_cnt (in-flight responses to discard), fault flag.
- pop = inst_valid & inst_ready.
- Issue: imem_req = !redirect_valid & !fault & (alloc_cnt + kill_cnt − pop < FIFO_DEPTH). imem_addr = fetch_pc.
- Grant (imem_req & imem_gnt): allocate tail entry with pc=fetch_pc, filled=0; fetch_pc += 4 (wraps mod 2^32).
- Response: if kill_cnt>0, discard and decrement kill_cnt; else write imem_rdata into oldest unfilled entry, set filled. Response with nothing outstanding is ignored.
- inst_valid = head entry allocated and filled. Pop frees the head.
- Redirect (highest priority): a pop in the same cycle still completes (decoder owns that instruction); then all entries freed, kill_cnt += number of allocated unfilled entries (minus one if a kept response arrives that cycle — i.e. a same-cycle response is counted as killed, not written); fetch_pc ← redirect_pc; no request that cycle.
- Back-to-back redirects: each accumulates kill_cnt; last one wins for fetch_pc.
- Reset mid-operation: all state cleared immediately; responses for pre-reset requests are the memory's responsibility to suppress.

## Timing
- Reset values: imem_req 0 (while rst_n low), imem_addr RESET_PC, inst_valid 0, instruction 0, inst_pc 0, fetch_fault 0, alloc_cnt 0, kill_cnt 0.
- First cycle after rst_n rises: imem_req=1, imem_addr=RESET_PC.
- Latency: grant in cycle N, rvalid in N+k → inst_valid in N+k+1 (response registered).
- With 1-cycle memory and inst_ready held high: sustained 1 instruction/cycle (pop frees credit combinationally).
- Full: alloc_cnt+kill_cnt=FIFO_DEPTH and no pop → imem_req=0.
- Redirect in cycle N → first request to redirect_pc in N+1.
- Outputs stable while inst_valid=1 and inst_ready=0.

## Configuration
- FETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0]≠00 sets fetch_fault (sticky until reset), flushes as normal, and blocks all further requests; inst_valid stays 0 afterwards.
- Not defined: redirect_pc[1:0] is ignored (treated as 00); fetch_fault tied 0.

## Test plan
- Reset release, 1-cycle memory returning addr-derived words, inst_ready=1 → PCs 0,4,8,… on consecutive cycles, first inst_valid 2 cycles after reset release.
- inst_ready=0 for 10 cycles → at most FIFO_DEPTH(4) grants, imem_req drops, head instruction/inst_pc constant; release → 4 pops back-to-back, in order.
- Redirect to 0x100 with 3 requests in flight on 3-cycle memory → 3 responses discarded, next inst_pc=0x100, no stale instruction seen.
- Redirect in the same cycle as a pop and as a response → popped instruction consumed once, response discarded, next inst_pc=redirect_pc.
- Random gnt/rvalid latency 1–5, random inst_ready, random redirects → scoreboard: every delivered inst_pc sequential since last redirect, data matches memory model.
- FETCH_MISALIGN_EN: redirect to 0x102 → fetch_fault=1 next cycle, imem_req stays 0; without macro → fetch restarts at 0x100.
